// File: rtl/lmc_core.sv
// lmc_core: accumulator CPU with separate program/data RAMs, fetch/execute FSM and valid/ready I/O.
module lmc_core #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  localparam int INSTR_WIDTH = 4 + ADDR_WIDTH
) (
  input  logic                   timer555,
  input  logic                   reset_count_n,
  input  logic                   start,
  input  logic                   prog_we,
  input  logic [ADDR_WIDTH-1:0]  prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  acc,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   z_flag,
  output logic                   p_flag,
  output logic                   c_flag,
  output logic                   halted
);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WAIT_IN, WAIT_OUT, HALT} state_t;
  localparam logic [3:0] OP_HLT = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_STA = 4'd3, OP_LDA = 4'd4,
                         OP_BRA = 4'd5, OP_BRZ = 4'd6, OP_BRP = 4'd7, OP_INP = 4'd8, OP_OUT = 4'd9;
  state_t state, state_nx;
  logic [INSTR_WIDTH-1:0] pmem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] dmem [2**ADDR_WIDTH];
  logic [INSTR_WIDTH-1:0] ir;
  logic [3:0] op;
  logic [ADDR_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] mem_q;
  logic [DATA_WIDTH:0] sum, dif;
  logic idle;
  assign op = ir[INSTR_WIDTH-1 -: 4];
  assign a = ir[ADDR_WIDTH-1:0];
  assign mem_q = dmem[a];
  // top bit of the extended difference is the borrow
  assign sum = {1'b0, acc} + {1'b0, mem_q};
  assign dif = {1'b0, acc} - {1'b0, mem_q};
  assign idle = state == IDLE || state == HALT;
  assign z_flag = acc == '0;
  assign p_flag = ~acc[DATA_WIDTH-1];
  assign in_ready = state == WAIT_IN;
  assign out_valid = state == WAIT_OUT;
  assign halted = state == HALT;
  always_ff @(posedge timer555 or negedge reset_count_n)
    if (!reset_count_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, HALT: state_nx = start ? FETCH : state;
      FETCH:      state_nx = EXEC;
      EXEC:       state_nx = op == OP_HLT ? HALT : op == OP_INP ? WAIT_IN : op == OP_OUT ? WAIT_OUT : FETCH;
      WAIT_IN:    state_nx = in_valid ? FETCH : WAIT_IN;
      WAIT_OUT:   state_nx = out_ready ? FETCH : WAIT_OUT;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge timer555 or negedge reset_count_n)
    if (!reset_count_n) begin
      pc <= '0;
      acc <= '0;
      c_flag <= 1'b0;
      out_data <= '0;
      ir <= '0;
    end else begin
      if (idle && start) pc <= '0;
      if (state == FETCH) begin
        ir <= pmem[pc];
        pc <= pc + ADDR_WIDTH'(1);
      end
      if (state == WAIT_IN && in_valid) acc <= in_data;
      if (state == EXEC)
        case (op)
          OP_ADD:  {c_flag, acc} <= sum;
          OP_SUB:  {c_flag, acc} <= dif;
          OP_LDA:  acc <= mem_q;
          OP_BRA:  pc <= a;
          OP_BRZ:  if (z_flag) pc <= a;
          OP_BRP:  if (p_flag) pc <= a;
          OP_OUT:  out_data <= acc;
          default: ;
        endcase
    end
  // RAMs carry no reset so their contents survive reset_count_n
  always_ff @(posedge timer555) begin
    if (idle && prog_we) pmem[prog_addr] <= prog_data;
    if (state == EXEC && op == OP_STA) dmem[a] <= acc;
  end
endmodule

// File: tb/tb_lmc_core.sv
// tb_lmc_core: directed program table, handshake corner sequences and random programs vs an ISA model.
module tb_lmc_core;
  logic timer555 = 0, reset_count_n = 0, start = 0, prog_we = 0, in_valid = 0, out_ready = 0;
  logic [3:0] prog_addr = 0;
  logic [7:0] prog_data = 0, in_data = 0;
  logic in_ready, out_valid, z_flag, p_flag, c_flag, halted;
  logic [7:0] out_data, acc;
  logic [3:0] pc;

  lmc_core #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .timer555(timer555), .reset_count_n(reset_count_n), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .acc(acc), .pc(pc), .z_flag(z_flag), .p_flag(p_flag), .c_flag(c_flag), .halted(halted)
  );

  always #5 timer555 = ~timer555;

  int checks = 0, failures = 0;
  logic [7:0] prog [16];
  logic [7:0] mi [8];
  logic [7:0] in_vec [$];
  logic [7:0] got_out [$];
  logic [7:0] m_dmem [16];
  logic [7:0] m_out [$];
  logic [7:0] m_acc;
  logic m_c;
  logic [3:0] m_pc;

  typedef struct {
    logic [0:15][7:0] prog;
    logic [0:3][7:0] ins;
    logic [0:3][7:0] outs;
    int n_out;
    logic [7:0] acc;
    logic c;
    logic [3:0] pc;
  } vec_t;
  vec_t tv [6];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_count_n = 0; start = 0; prog_we = 0; in_valid = 0; out_ready = 0;
    repeat (2) @(negedge timer555);
    reset_count_n = 1;
    @(negedge timer555);
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      @(negedge timer555);
      prog_we = 1; prog_addr = 4'(i); prog_data = prog[i];
    end
    @(negedge timer555);
    prog_we = 0;
  endtask

  task automatic run_dut();
    got_out.delete();
    @(negedge timer555); start = 1;
    @(negedge timer555); start = 0;
    for (int i = 0; i < 1000 && !halted; i++) begin
      out_ready = $urandom_range(0, 3) != 0;
      if (out_valid && out_ready) got_out.push_back(out_data);
      in_valid = in_ready && in_vec.size() > 0 && $urandom_range(0, 3) != 0;
      if (in_valid) in_data = in_vec.pop_front();
      @(negedge timer555);
    end
    in_valid = 0; out_ready = 0;
  endtask

  // instruction-level interpreter; commits state only for programs that halt cleanly
  task automatic model_run(output bit ok);
    logic [7:0] d [16];
    logic [7:0] a_;
    logic [3:0] p_, op, ad;
    bit c_, stop;
    int ni, s;
    d = m_dmem; a_ = 0; c_ = 0; p_ = 0; ni = 0; ok = 0; stop = 0;
    m_out.delete();
    for (int k = 0; k < 60 && !stop; k++) begin
      op = prog[p_][7:4]; ad = prog[p_][3:0]; p_ = p_ + 4'd1;
      case (op)
        0: begin ok = 1; stop = 1; end
        1: begin s = int'(a_) + int'(d[ad]); c_ = s > 255; a_ = 8'(s); end
        2: begin s = int'(a_) - int'(d[ad]); c_ = s < 0; a_ = 8'(s); end
        3: d[ad] = a_;
        4: a_ = d[ad];
        5: p_ = ad;
        6: if (a_ == 0) p_ = ad;
        7: if (a_ < 128) p_ = ad;
        8: if (ni < 8) begin a_ = mi[ni]; ni++; end else stop = 1;
        9: m_out.push_back(a_);
        default: ;
      endcase
    end
    if (ok) begin
      m_dmem = d; m_acc = a_; m_c = c_; m_pc = p_;
    end
  endtask

  task automatic run_vs_model(string tag);
    do_reset();
    load_prog();
    in_vec.delete();
    foreach (mi[i]) in_vec.push_back(mi[i]);
    run_dut();
    chk({tag, "_halted"}, halted, 1);
    chk({tag, "_nout"}, got_out.size(), m_out.size());
    for (int i = 0; i < got_out.size() && i < m_out.size(); i++) chk({tag, "_out"}, got_out[i], m_out[i]);
    chk({tag, "_acc"}, acc, m_acc);
    chk({tag, "_c"}, c_flag, m_c);
    chk({tag, "_pc"}, pc, m_pc);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    tv[0] = '{prog: {8'h80, 8'h37, 8'h80, 8'h17, 8'h90, 8'h00, 80'h0}, ins: {8'd5, 8'd3, 16'h0},
              outs: {8'd8, 24'h0}, n_out: 1, acc: 8'd8, c: 1'b0, pc: 4'd6};
    tv[1] = '{prog: {8'h80, 8'h39, 8'h80, 8'h19, 8'h90, 8'h00, 80'h0}, ins: {8'd100, 8'd200, 16'h0},
              outs: {8'd44, 24'h0}, n_out: 1, acc: 8'd44, c: 1'b1, pc: 4'd6};
    tv[2] = '{prog: {8'h80, 8'h35, 8'h80, 8'h25, 8'h90, 8'h00, 80'h0}, ins: {8'd5, 8'd3, 16'h0},
              outs: {8'd254, 24'h0}, n_out: 1, acc: 8'd254, c: 1'b1, pc: 4'd6};
    tv[3] = '{prog: {8'h80, 8'h3F, 8'h80, 8'h90, 8'h2F, 8'h67, 8'h53, 8'h00, 64'h0}, ins: {8'd1, 8'd3, 16'h0},
              outs: {8'd3, 8'd2, 8'd1, 8'h0}, n_out: 3, acc: 8'd0, c: 1'b0, pc: 4'd8};
    tv[4] = '{prog: {8'h80, 8'h74, 8'h90, 8'h00, 8'h3C, 8'h4C, 8'h1C, 8'h72, 8'hA0, 8'h00, 48'h0},
              ins: {8'h7F, 24'h0}, outs: 32'h0, n_out: 0, acc: 8'hFE, c: 1'b0, pc: 4'd10};
    tv[5] = '{prog: {8'h7D, 8'h00, 88'h0, 8'h80, 8'h90, 8'hA0}, ins: {8'd5, 8'h80, 16'h0},
              outs: {8'd5, 8'h80, 16'h0}, n_out: 2, acc: 8'h80, c: 1'b0, pc: 4'd2};

    do_reset();
    chk("rst_pc", pc, 0);
    chk("rst_acc", acc, 0);
    chk("rst_c", c_flag, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_halted", halted, 0);
    chk("rst_z", z_flag, 1);
    chk("rst_p", p_flag, 1);

    for (int t = 0; t < 6; t++) begin
      do_reset();
      for (int i = 0; i < 16; i++) prog[i] = tv[t].prog[i];
      load_prog();
      in_vec.delete();
      for (int i = 0; i < 4; i++) in_vec.push_back(tv[t].ins[i]);
      run_dut();
      chk($sformatf("tv%0d_halted", t), halted, 1);
      chk($sformatf("tv%0d_nout", t), got_out.size(), tv[t].n_out);
      for (int i = 0; i < got_out.size() && i < tv[t].n_out; i++)
        chk($sformatf("tv%0d_out%0d", t, i), got_out[i], tv[t].outs[i]);
      chk($sformatf("tv%0d_acc", t), acc, tv[t].acc);
      chk($sformatf("tv%0d_c", t), c_flag, tv[t].c);
      chk($sformatf("tv%0d_pc", t), pc, tv[t].pc);
      chk($sformatf("tv%0d_z", t), z_flag, tv[t].acc == 0);
      chk($sformatf("tv%0d_p", t), p_flag, !tv[t].acc[7]);
    end

    // output stall with an ignored program write, then reset while waiting on the consumer
    do_reset();
    foreach (prog[i]) prog[i] = 8'h00;
    prog[0] = 8'h80; prog[1] = 8'h90;
    load_prog();
    @(negedge timer555); start = 1;
    @(negedge timer555); start = 0;
    for (int i = 0; i < 50 && !out_valid; i++) begin
      in_valid = in_ready; in_data = 8'hA5;
      @(negedge timer555);
    end
    in_valid = 0;
    chk("stall_reach_wait_out", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      prog_we = i == 3; prog_addr = 4'd2; prog_data = 8'h91;
      @(negedge timer555);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_data", out_data, 8'hA5);
    end
    prog_we = 0;
    chk("stall_pc", pc, 2);
    reset_count_n = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_pc", pc, 0);
    chk("midrst_acc", acc, 0);
    chk("midrst_halted", halted, 0);
    chk("midrst_out_data", out_data, 0);
    @(negedge timer555); reset_count_n = 1;
    @(negedge timer555);
    in_vec = '{8'h3C};
    run_dut();
    chk("rerun_halted", halted, 1);
    chk("rerun_nout", got_out.size(), 1);
    if (got_out.size() > 0) chk("rerun_out", got_out[0], 8'h3C);
    chk("rerun_pc", pc, 3);

    // start and a program write in the same idle cycle
    do_reset();
    @(negedge timer555); start = 1; prog_we = 1; prog_addr = 4'd0; prog_data = 8'h00;
    @(negedge timer555); start = 0; prog_we = 0;
    chk("sw_fetch_halted", halted, 0);
    @(negedge timer555);
    chk("sw_exec_halted", halted, 0);
    chk("sw_exec_pc", pc, 1);
    @(negedge timer555);
    chk("sw_halted", halted, 1);
    chk("sw_pc", pc, 1);

    // fill every data word through the core so the model knows all of DMEM
    for (int k = 0; k < 3; k++) begin
      foreach (prog[i]) prog[i] = 8'h00;
      for (int j = 0; j < 7; j++)
        if (k * 7 + j < 16) begin
          prog[2 * j] = 8'h80;
          prog[2 * j + 1] = {4'h3, 4'(k * 7 + j)};
        end
      foreach (mi[i]) mi[i] = 8'($urandom);
      model_run(ok);
      run_vs_model($sformatf("init%0d", k));
    end

    for (int r = 0; r < 20; r++) begin
      ok = 0;
      for (int tries = 0; tries < 2000 && !ok; tries++) begin
        foreach (prog[i]) prog[i] = 8'($urandom);
        foreach (mi[i]) mi[i] = 8'($urandom);
        model_run(ok);
      end
      if (ok) run_vs_model($sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
